// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter
//   Sequential binary-to-BCD converter (double dabble, one bit per clock).
//   Converts a binary result, optionally two's complement, into packed BCD
//   digits plus a sign flag for the seven-segment display path.
// Ports:
//   clk          rising-edge system clock
//   rst          asynchronous reset, active low
//   start        request a conversion; sampled only while idle
//   bin_in       binary value, captured on the accepting edge
//   signed_mode  1: bin_in is two's complement; captured with bin_in
//   busy         conversion in progress
//   done         one-cycle pulse: bcd_out/neg_out just updated
//   bcd_out      packed BCD, digit 0 in [3:0]
//   neg_out      result is negative
module bin_to_bcd_converter #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out
);

    localparam int unsigned SCR_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned MAG_W = BIN_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scr_q,   scr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sign_q,  sign_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [SCR_W-1:0]   bcd_q,   bcd_d;
    logic               neg_q,   neg_d;

    logic [SCR_W-1:0]   adj_c;
    logic [MAG_W-1:0]   neg_mag_c;
    logic               is_neg_c;

    // Add-3 pass: bump every scratch digit >= 5 before the shift.
    always_comb begin
        adj_c = scr_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Negation in BIN_W+1 bits so the most negative input yields its full magnitude.
    always_comb begin
        neg_mag_c = MAG_W'(0) - {1'b0, bin_in};
        is_neg_c  = signed_mode & bin_in[BIN_W-1];
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        count_d = count_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        neg_d   = neg_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = is_neg_c ? neg_mag_c[BIN_W-1:0] : bin_in;
                    scr_d   = '0;
                    sign_d  = is_neg_c;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d   = {adj_c[SCR_W-2:0], shift_q[BIN_W-1]};
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = {adj_c[SCR_W-2:0], shift_q[BIN_W-1]};
                    neg_d   = sign_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            count_q <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
        end
    end

    // A carry out of the top digit means DIGITS is too small for BIN_W.
    always_ff @(posedge clk) begin
        if (rst && (state_q == SHIFT)) begin
            assert (!adj_c[SCR_W-1]);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign neg_out = neg_q;

endmodule
